// File: rtl/riscv_test_sequencer.sv
// Multi-program self-test sequencer: resets and boots the core once per selected program, collects pass/timeout.
// Latency: 1 (SELECT) + RST_CYCLES + run + 1 (RECORD) cycles per program, plus 1 final SELECT.
// Backpressure: none; start_i is only honoured in IDLE and exit_valid_i only in RUN.
module riscv_test_sequencer #(
   parameter int unsigned NUM_TESTS      = 4,
   parameter int unsigned TIMEOUT_WIDTH  = 20,
   parameter int unsigned RST_CYCLES     = 4,
   parameter logic [31:0] BOOT_ADDR_BASE = 32'h80,
   parameter logic [31:0] BOOT_STRIDE    = 32'h1000,
   localparam int unsigned IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
   localparam int unsigned RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [NUM_TESTS-1:0]     test_mask_i,
   input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles_i,
   input  logic                     exit_valid_i,
   input  logic [31:0]              exit_value_i,
   output logic                     core_rst_no,
   output logic                     fetch_enable_o,
   output logic [31:0]              boot_addr_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     go_nogo_o,
   output logic [IDX_W-1:0]         cur_idx_o,
   output logic [NUM_TESTS-1:0]     result_o,
   output logic [NUM_TESTS-1:0]     timeout_o
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SELECT   = 3'd1,
      CORE_RST = 3'd2,
      RUN      = 3'd3,
      RECORD   = 3'd4
   } state_t;

   state_t                   state_q, state_d;
   logic [NUM_TESTS-1:0]     pending_q;
   logic [NUM_TESTS-1:0]     mask_q;
   logic [TIMEOUT_WIDTH-1:0] tmo_q;
   logic [TIMEOUT_WIDTH-1:0] wd_cnt_q;
   logic [RC_W-1:0]          rst_cnt_q;
   logic [IDX_W-1:0]         cur_idx_q;
   logic [31:0]              boot_addr_q;
   logic [NUM_TESTS-1:0]     result_q;
   logic [NUM_TESTS-1:0]     timeout_q;
   logic                     done_q;
   logic                     go_q;
   logic                     core_rst_nq;
   logic                     fetch_q;
   logic                     busy_q;

   logic                     sel_found;
   logic [IDX_W-1:0]         sel_idx;
   logic [31:0]              sel_addr;
   logic                     wd_expire;
   logic                     rst_last;

   // Lowest pending program index; scanning downward leaves the lowest set bit as the winner.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = int'(NUM_TESTS) - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   assign sel_addr  = BOOT_ADDR_BASE + (32'(sel_idx) * BOOT_STRIDE);
   // Counter starts at 0 on the first RUN cycle, so value timeout-1 marks the timeout-th RUN cycle.
   assign wd_expire = (tmo_q != '0) && (wd_cnt_q == (tmo_q - TIMEOUT_WIDTH'(1)));
   assign rst_last  = (rst_cnt_q == RC_W'(RST_CYCLES - 1));

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decision.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = SELECT;
         end
         SELECT: begin
            state_d = sel_found ? CORE_RST : IDLE;
         end
         CORE_RST: begin
            if (rst_last) state_d = RUN;
         end
         RUN: begin
            if (exit_valid_i || wd_expire) state_d = RECORD;
         end
         RECORD: begin
            state_d = SELECT;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered outputs; core controls and busy follow the state being entered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q   <= '0;
         mask_q      <= '0;
         tmo_q       <= '0;
         wd_cnt_q    <= '0;
         rst_cnt_q   <= '0;
         cur_idx_q   <= '0;
         boot_addr_q <= BOOT_ADDR_BASE;
         result_q    <= '0;
         timeout_q   <= '0;
         done_q      <= 1'b0;
         go_q        <= 1'b0;
         core_rst_nq <= 1'b0;
         fetch_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         core_rst_nq <= (state_d == RUN);
         fetch_q     <= (state_d == RUN);
         busy_q      <= (state_d != IDLE);
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  pending_q <= test_mask_i;
                  mask_q    <= test_mask_i;
                  tmo_q     <= timeout_cycles_i;
                  result_q  <= '0;
                  timeout_q <= '0;
                  done_q    <= 1'b0;
                  go_q      <= 1'b0;
               end
            end
            SELECT: begin
               if (sel_found) begin
                  cur_idx_q   <= sel_idx;
                  boot_addr_q <= sel_addr;
                  rst_cnt_q   <= '0;
               end else begin
                  done_q <= 1'b1;
                  go_q   <= (mask_q != '0) && (result_q == mask_q);
               end
            end
            CORE_RST: begin
               rst_cnt_q <= rst_cnt_q + RC_W'(1);
               wd_cnt_q  <= '0;
            end
            RUN: begin
               if (wd_cnt_q != '1) wd_cnt_q <= wd_cnt_q + TIMEOUT_WIDTH'(1);
               // An exit in the expiry cycle takes priority over the watchdog.
               if (exit_valid_i) begin
                  result_q[cur_idx_q] <= (exit_value_i == 32'd0);
               end else if (wd_expire) begin
                  timeout_q[cur_idx_q] <= 1'b1;
                  result_q[cur_idx_q]  <= 1'b0;
               end
            end
            RECORD: begin
               pending_q[cur_idx_q] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign core_rst_no    = core_rst_nq;
   assign fetch_enable_o = fetch_q;
   assign boot_addr_o    = boot_addr_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign go_nogo_o      = go_q;
   assign cur_idx_o      = cur_idx_q;
   assign result_o       = result_q;
   assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_riscv_test_sequencer.sv
// Bench for riscv_test_sequencer: directed test-plan scenarios plus randomized sequences.
// Latency: expectations derived from per-program run lengths and fixed per-program overhead.
// Backpressure: none; the bench acts as the core/mm_ram exit responder.
module tb_riscv_test_sequencer;
   localparam int NT   = 4;
   localparam int RSTC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  mask_in = '0;
   logic [19:0] tmo_in = '0;
   logic        exit_vld = 1'b0;
   logic [31:0] exit_val = '0;

   logic        core_rst_no, fetch_enable_o, busy_o, done_o, go_nogo_o;
   logic [31:0] boot_addr_o;
   logic [1:0]  cur_idx_o;
   logic [3:0]  result_o, timeout_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   riscv_test_sequencer #(
      .NUM_TESTS(NT), .TIMEOUT_WIDTH(20), .RST_CYCLES(RSTC),
      .BOOT_ADDR_BASE(32'h80), .BOOT_STRIDE(32'h1000)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .test_mask_i(mask_in),
      .timeout_cycles_i(tmo_in), .exit_valid_i(exit_vld), .exit_value_i(exit_val),
      .core_rst_no(core_rst_no), .fetch_enable_o(fetch_enable_o), .boot_addr_o(boot_addr_o),
      .busy_o(busy_o), .done_o(done_o), .go_nogo_o(go_nogo_o), .cur_idx_o(cur_idx_o),
      .result_o(result_o), .timeout_o(timeout_o)
   );

   // Runs one complete sequence. dly[i] = RUN cycle on which program i exits (0 = never), val[i] = exit code.
   task automatic run_seq(input string name, input logic [3:0] mask, input int tmo,
                          input int dly [4], input logic [31:0] val [4]);
      int q_idx[$];
      int q_run[$];
      logic [3:0] e_res, e_to;
      logic e_go;
      int total, n, r, gap, k_cur, run_exp, idx_cur, rl;
      logic prev_fe, fin, first, timed;
      e_res = '0; e_to = '0; total = 0;
      for (int i = 0; i < NT; i++) begin
         if (mask[i]) begin
            timed = (tmo != 0) && (dly[i] == 0 || dly[i] > tmo);
            rl    = timed ? tmo : dly[i];
            e_to[i]  = timed;
            e_res[i] = !timed && (val[i] == 32'd0);
            q_idx.push_back(i);
            q_run.push_back(rl);
            total += 1 + RSTC + 1 + rl;
         end
      end
      total += 2;
      e_go = (mask != 4'd0) && (e_res == mask);

      @(negedge clk);
      start = 1'b1; mask_in = mask; tmo_in = tmo[19:0]; exit_vld = 1'b0;
      n = 0; r = 0; gap = 0; prev_fe = 1'b0; fin = 1'b0; first = 1'b1;
      k_cur = 0; idx_cur = 0; run_exp = 0;
      while (!fin && n < 20000) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         n_vec++; if (core_rst_no !== fetch_enable_o) begin n_err++; $display("FAIL %s rst_vs_fetch n=%0d: core_rst_no=%b fetch=%b", name, n, core_rst_no, fetch_enable_o); end
         if (n == 1) begin
            n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL %s busy_after_start: got %b want 1", name, busy_o); end
            n_vec++; if ({done_o, go_nogo_o, result_o, timeout_o} !== 10'd0) begin n_err++; $display("FAIL %s cleared_on_start: done=%b go=%b res=%b to=%b want all 0", name, done_o, go_nogo_o, result_o, timeout_o); end
         end
         if (done_o) begin
            fin = 1'b1;
            n_vec++; if (n != total) begin n_err++; $display("FAIL %s total_cycles: got %0d want %0d", name, n, total); end
         end else begin
            if (fetch_enable_o && !prev_fe) begin
               if (q_idx.size() == 0) begin
                  n_vec++; n_err++; $display("FAIL %s unexpected_release: got idx %0d want none", name, cur_idx_o);
               end else begin
                  idx_cur = q_idx.pop_front();
                  run_exp = q_run.pop_front();
                  k_cur   = dly[idx_cur];
                  n_vec++; if (cur_idx_o !== 2'(idx_cur)) begin n_err++; $display("FAIL %s cur_idx: got %0d want %0d", name, cur_idx_o, idx_cur); end
                  n_vec++; if (boot_addr_o !== 32'h80 + 32'(idx_cur) * 32'h1000) begin n_err++; $display("FAIL %s boot_addr: got %h want %h", name, boot_addr_o, 32'h80 + 32'(idx_cur) * 32'h1000); end
                  n_vec++; if (gap != (first ? RSTC + 1 : RSTC + 2)) begin n_err++; $display("FAIL %s reset_gap: got %0d want %0d", name, gap, first ? RSTC + 1 : RSTC + 2); end
               end
               first = 1'b0;
               r = 0;
            end
            if (!fetch_enable_o && prev_fe) begin
               n_vec++; if (r != run_exp) begin n_err++; $display("FAIL %s run_cycles p%0d: got %0d want %0d", name, idx_cur, r, run_exp); end
               n_vec++; if (result_o[idx_cur] !== e_res[idx_cur]) begin n_err++; $display("FAIL %s record_result p%0d: got %b want %b", name, idx_cur, result_o[idx_cur], e_res[idx_cur]); end
               n_vec++; if (timeout_o[idx_cur] !== e_to[idx_cur]) begin n_err++; $display("FAIL %s record_timeout p%0d: got %b want %b", name, idx_cur, timeout_o[idx_cur], e_to[idx_cur]); end
               gap = 0;
            end
            if (fetch_enable_o) begin
               r++;
               exit_vld = (r == k_cur);
               exit_val = (r == k_cur) ? val[idx_cur] : $urandom;
            end else begin
               gap++;
               exit_vld = 1'($urandom_range(0, 1));
               exit_val = $urandom | 32'h1;
            end
            if (busy_o) begin
               start   = ($urandom_range(0, 3) == 0);
               mask_in = 4'($urandom);
               tmo_in  = 20'($urandom);
            end
            prev_fe = fetch_enable_o;
         end
      end
      start = 1'b0; exit_vld = 1'b0;
      if (!fin) begin
         n_vec++; n_err++; $display("FAIL %s done_timeout: got no done after %0d cycles want %0d", name, n, total);
      end
      n_vec++; if (q_idx.size() != 0) begin n_err++; $display("FAIL %s programs_missing: got %0d unrun want 0", name, q_idx.size()); end
      n_vec++; if (result_o !== e_res) begin n_err++; $display("FAIL %s result: got %b want %b", name, result_o, e_res); end
      n_vec++; if (timeout_o !== e_to) begin n_err++; $display("FAIL %s timeout: got %b want %b", name, timeout_o, e_to); end
      n_vec++; if (go_nogo_o !== e_go) begin n_err++; $display("FAIL %s go_nogo: got %b want %b", name, go_nogo_o, e_go); end
      n_vec++; if ({busy_o, core_rst_no, fetch_enable_o} !== 3'b000) begin n_err++; $display("FAIL %s idle_ctrl: busy=%b rst_n=%b fetch=%b want 000", name, busy_o, core_rst_no, fetch_enable_o); end
      repeat (3) @(negedge clk);
      n_vec++; if ({done_o, go_nogo_o, result_o, timeout_o} !== {1'b1, e_go, e_res, e_to}) begin n_err++; $display("FAIL %s hold: done=%b go=%b res=%b to=%b want 1 %b %b %b", name, done_o, go_nogo_o, result_o, timeout_o, e_go, e_res, e_to); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if ({core_rst_no, fetch_enable_o, busy_o, done_o, go_nogo_o} !== 5'd0) begin n_err++; $display("FAIL reset ctrl: got %b want 00000", {core_rst_no, fetch_enable_o, busy_o, done_o, go_nogo_o}); end
      n_vec++; if (boot_addr_o !== 32'h80) begin n_err++; $display("FAIL reset boot_addr: got %h want 00000080", boot_addr_o); end
      n_vec++; if ({cur_idx_o, result_o, timeout_o} !== 10'd0) begin n_err++; $display("FAIL reset idx_res_to: got %b want 0", {cur_idx_o, result_o, timeout_o}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      int d [4];
      logic [31:0] v [4];
      d = '{100, 100, 100, 100}; v = '{32'd0, 32'd0, 32'd0, 32'd0};
      run_seq("all_pass", 4'b1011, 0, d, v);
      d = '{10, 40, 25, 10}; v = '{32'd0, 32'h5, 32'd0, 32'd0};
      run_seq("one_fail", 4'b0110, 0, d, v);
      d = '{0, 20, 10, 10}; v = '{32'd0, 32'd0, 32'd0, 32'd0};
      run_seq("watchdog", 4'b0011, 50, d, v);
      d = '{50, 10, 10, 10}; v = '{32'd0, 32'd0, 32'd0, 32'd0};
      run_seq("coincide", 4'b0001, 50, d, v);
      run_seq("empty_mask", 4'b0000, 0, d, v);
   endtask

   task automatic test_random();
      int d [4];
      logic [31:0] v [4];
      logic [3:0] m;
      int t;
      for (int it = 0; it < 8; it++) begin
         m = 4'($urandom);
         t = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 60);
         for (int i = 0; i < NT; i++) begin
            d[i] = $urandom_range(1, 80);
            if (t != 0 && $urandom_range(0, 4) == 0) d[i] = 0;
            if (t != 0 && $urandom_range(0, 4) == 0) d[i] = t;
            v[i] = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1) : 32'd0;
         end
         run_seq("random", m, t, d, v);
      end
   endtask

   task automatic test_reset_mid_run();
      int d [4];
      logic [31:0] v [4];
      int r, cnt;
      logic seen;
      @(negedge clk);
      start = 1'b1; mask_in = 4'hF; tmo_in = '0;
      @(negedge clk);
      start = 1'b0;
      r = 0; cnt = 0; seen = 1'b0;
      while (!seen && cnt < 2000) begin
         cnt++;
         if (fetch_enable_o && cur_idx_o == 2'd2) begin
            seen = 1'b1;
         end else begin
            if (fetch_enable_o) begin r++; exit_vld = (r == 10); exit_val = 32'd0; end
            else begin r = 0; exit_vld = 1'b0; end
            @(negedge clk);
         end
      end
      exit_vld = 1'b0;
      n_vec++; if (!seen) begin n_err++; $display("FAIL midrun reach_prog2: got no RUN of program 2 want one"); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if ({core_rst_no, fetch_enable_o, busy_o, done_o, go_nogo_o} !== 5'd0) begin n_err++; $display("FAIL midrun async_ctrl: got %b want 00000", {core_rst_no, fetch_enable_o, busy_o, done_o, go_nogo_o}); end
      n_vec++; if (boot_addr_o !== 32'h80) begin n_err++; $display("FAIL midrun async_boot: got %h want 00000080", boot_addr_o); end
      n_vec++; if ({cur_idx_o, result_o, timeout_o} !== 10'd0) begin n_err++; $display("FAIL midrun async_state: got %b want 0", {cur_idx_o, result_o, timeout_o}); end
      repeat (3) @(negedge clk);
      n_vec++; if ({core_rst_no, busy_o} !== 2'b00) begin n_err++; $display("FAIL midrun held: rst_n=%b busy=%b want 00", core_rst_no, busy_o); end
      rst_n = 1'b1;
      @(negedge clk);
      d = '{15, 5, 30, 8}; v = '{32'd0, 32'd0, 32'd0, 32'd0};
      run_seq("after_reset", 4'hF, 0, d, v);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
